// File: rtl/pp_mon_pkg.sv
// Shared types and helpers for the pipelined-loop activity monitor.
package pp_mon_pkg;

  // Block-level handshake state: waiting for a start, or running a transaction
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mod_state_e;

  // Saturating increment on a counter of the given width (up to 64 bits);
  // a counter already at all-ones stays at all-ones
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] maxVal;
    maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= maxVal) ? maxVal : value + 64'd1;
  endfunction

endpackage

// File: rtl/hs_txn_tracker.sv
// Tracks one ap_start/ap_done/ap_continue transaction at a time: busy flag,
// completed-run count and start-to-done latency of the most recent run.
module hs_txn_tracker
  import pp_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             ap_start_i,
  input  logic             ap_done_i,
  input  logic             ap_continue_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] runs_o,
  output logic [CNT_W-1:0] last_lat_o
);

  mod_state_e       state_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] runs_q;
  logic [CNT_W-1:0] lastLat_q;

  // A run only completes when done is acknowledged by continue; an
  // unacknowledged done keeps the block busy and the latency still counting
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      runs_q    <= '0;
      lastLat_q <= '0;
    end else if (!hold_i) begin
      case (state_q)
        IDLE: begin
          if (ap_start_i) begin
            if (ap_done_i && ap_continue_i) begin
              runs_q    <= CNT_W'(sat_inc(64'(runs_q), CNT_W));
              lastLat_q <= CNT_W'(1);
            end else begin
              state_q <= BUSY;
              lat_q   <= CNT_W'(1);
            end
          end
        end
        BUSY: begin
          if (ap_done_i && ap_continue_i) begin
            state_q   <= IDLE;
            runs_q    <= CNT_W'(sat_inc(64'(runs_q), CNT_W));
            lastLat_q <= lat_q;
          end else begin
            lat_q <= CNT_W'(sat_inc(64'(lat_q), CNT_W));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == BUSY);
  assign runs_o     = runs_q;
  assign last_lat_o = lastLat_q;

endmodule

// File: rtl/pp_loop_activity_tracker.sv
// Passive monitor for an HLS block handshake and one pipelined loop inside it:
// counts runs, loop entries, iteration starts/ends, active and stall cycles.
module pp_loop_activity_tracker
  import pp_mon_pkg::*;
#(
  parameter int unsigned STATE_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state0,
  input  logic               pre_states_valid,
  input  logic [STATE_W-1:0] post_loop_state0,
  input  logic               post_states_valid,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic               iter_start_enable,
  input  logic               iter_start_block,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_end_enable,
  input  logic               iter_end_block,
  input  logic [STATE_W-1:0] loop_quit_state,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic               module_busy,
  output logic [CNT_W-1:0]   module_runs,
  output logic [CNT_W-1:0]   module_last_lat,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_entries,
  output logic [CNT_W-1:0]   iter_starts,
  output logic [CNT_W-1:0]   iter_ends,
  output logic [CNT_W-1:0]   iter_inflight,
  output logic [CNT_W-1:0]   loop_cycles,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               frozen
);

  logic               frozen_q;
  logic               active_q, active_d;
  logic [STATE_W-1:0] prevState_q;
  logic [CNT_W-1:0]   entries_q, entries_d;
  logic [CNT_W-1:0]   starts_q, starts_d;
  logic [CNT_W-1:0]   ends_q, ends_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   stalls_q, stalls_d;

  logic hold;
  logic sHit, eHit, q0Hit;
  logic entry, inLoop, startCount, endCount;
  logic exitAtEnd, exitOnLeave, exitForced, loopExit;
  logic unusedReady;

  // ap_ready carries no information the counters need; it is accepted so the
  // monitor can be wired straight onto the full handshake bundle
  assign unusedReady = ap_ready;

  // The freeze takes effect in the same cycle finish is seen
  assign hold = frozen_q | finish;

  hs_txn_tracker #(
    .CNT_W(CNT_W)
  ) u_hs (
    .clock        (clock),
    .reset        (reset),
    .hold_i       (hold),
    .ap_start_i   (ap_start),
    .ap_done_i    (ap_done),
    .ap_continue_i(ap_continue),
    .busy_o       (module_busy),
    .runs_o       (module_runs),
    .last_lat_o   (module_last_lat)
  );

  // Decode iteration events, loop entry/exit and the next counter values
  always_comb begin
    sHit  = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    eHit  = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    q0Hit = (cur_state == loop_quit_state);

    entry  = ~active_q & (cur_state == iter_start_state)
           & (~pre_states_valid | (prevState_q == pre_loop_state0));
    inLoop = active_q | entry;

    startCount = inLoop & sHit;
    endCount   = inLoop & eHit & (inflight_q != '0);

    exitAtEnd   = quit_at_end & q0Hit & eHit & ~sHit & (inflight_q == CNT_W'(1));
    exitOnLeave = ~quit_at_end & (prevState_q == loop_quit_state) & ~q0Hit;
    exitForced  = post_states_valid & (cur_state == post_loop_state0);
    loopExit    = active_q & (exitAtEnd | exitOnLeave | exitForced);

    active_d   = active_q ? ~loopExit : entry;
    entries_d  = entry      ? CNT_W'(sat_inc(64'(entries_q), CNT_W)) : entries_q;
    starts_d   = startCount ? CNT_W'(sat_inc(64'(starts_q), CNT_W))  : starts_q;
    ends_d     = endCount   ? CNT_W'(sat_inc(64'(ends_q), CNT_W))    : ends_q;
    cycles_d   = inLoop     ? CNT_W'(sat_inc(64'(cycles_q), CNT_W))  : cycles_q;
    stalls_d   = (inLoop & iter_start_block) ? CNT_W'(sat_inc(64'(stalls_q), CNT_W)) : stalls_q;
    inflight_d = starts_d - ends_d;
  end

  // Loop state registers; everything except the sticky freeze flag holds once frozen
  always_ff @(posedge clock) begin
    if (reset) begin
      frozen_q    <= 1'b0;
      active_q    <= 1'b0;
      prevState_q <= '0;
      entries_q   <= '0;
      starts_q    <= '0;
      ends_q      <= '0;
      inflight_q  <= '0;
      cycles_q    <= '0;
      stalls_q    <= '0;
    end else begin
      frozen_q <= frozen_q | finish;
      if (!hold) begin
        active_q    <= active_d;
        prevState_q <= cur_state;
        entries_q   <= entries_d;
        starts_q    <= starts_d;
        ends_q      <= ends_d;
        inflight_q  <= inflight_d;
        cycles_q    <= cycles_d;
        stalls_q    <= stalls_d;
      end
    end
  end

  assign loop_active   = active_q;
  assign loop_entries  = entries_q;
  assign iter_starts   = starts_q;
  assign iter_ends     = ends_q;
  assign iter_inflight = inflight_q;
  assign loop_cycles   = cycles_q;
  assign stall_cycles  = stalls_q;
  assign frozen        = frozen_q;

endmodule

// File: tb/tb_pp_loop_activity_tracker.sv
// Scoreboard bench for pp_loop_activity_tracker: a 32-bit and a 4-bit instance
// share stimulus; a behavioural model predicts every cycle's outputs.
module tb_pp_loop_activity_tracker;

  localparam logic [4:0] PRE_ST   = 5'd4;
  localparam logic [4:0] LOOP_ST  = 5'd5;
  localparam logic [4:0] POST_ST  = 5'd6;
  localparam logic [4:0] OTHER_ST = 5'd7;

  logic       clock = 1'b0;
  logic       reset, ap_start, ap_ready, ap_done, ap_continue;
  logic [4:0] cur_state, pre_loop_state0, post_loop_state0;
  logic [4:0] iter_start_state, iter_end_state, loop_quit_state;
  logic       pre_states_valid, post_states_valid;
  logic       iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
  logic       quit_at_end, finish;

  logic        busy32, active32, frozen32;
  logic [31:0] runs32, lastLat32, entries32, starts32, ends32, inflight32, cycles32, stalls32;
  logic        busy4, active4, frozen4;
  logic [3:0]  runs4, lastLat4, entries4, starts4, ends4, inflight4, cycles4, stalls4;

  typedef struct packed {
    logic        busy;
    logic [31:0] runs;
    logic [31:0] lastLat;
    logic        active;
    logic [31:0] entries;
    logic [31:0] starts;
    logic [31:0] ends;
    logic [31:0] inflight;
    logic [31:0] cycles;
    logic [31:0] stalls;
    logic        frozen;
  } obs_t;

  typedef struct {
    bit              busy;
    longint unsigned lat;
    longint unsigned runs;
    longint unsigned lastLat;
    bit              active;
    longint unsigned entries;
    longint unsigned starts;
    longint unsigned ends;
    longint unsigned cycles;
    longint unsigned stalls;
    bit              frozen;
    logic [4:0]      prev;
  } model_t;

  model_t m32, m4;
  obs_t   expQ32[$];
  obs_t   expQ4[$];
  int     checks = 0;
  int     errors = 0;
  int     cycleNo = 0;

  always #5 clock = ~clock;

  pp_loop_activity_tracker #(.STATE_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cur_state(cur_state),
    .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
    .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end), .finish(finish),
    .module_busy(busy32), .module_runs(runs32), .module_last_lat(lastLat32),
    .loop_active(active32), .loop_entries(entries32), .iter_starts(starts32),
    .iter_ends(ends32), .iter_inflight(inflight32), .loop_cycles(cycles32),
    .stall_cycles(stalls32), .frozen(frozen32)
  );

  pp_loop_activity_tracker #(.STATE_W(5), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cur_state(cur_state),
    .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
    .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end), .finish(finish),
    .module_busy(busy4), .module_runs(runs4), .module_last_lat(lastLat4),
    .loop_active(active4), .loop_entries(entries4), .iter_starts(starts4),
    .iter_ends(ends4), .iter_inflight(inflight4), .loop_cycles(cycles4),
    .stall_cycles(stalls4), .frozen(frozen4)
  );

  function automatic longint unsigned satInc(input longint unsigned v, input longint unsigned maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Reference behaviour for one clock edge, given the inputs currently driven
  function automatic model_t modelStep(input model_t m, input longint unsigned maxv);
    model_t          n;
    bit              enter, inLoop, s, e, leave;
    longint unsigned pending;
    n = m;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    if (m.frozen || finish) begin
      n.frozen = 1'b1;
      return n;
    end
    if (!m.busy) begin
      if (ap_start) begin
        if (ap_done && ap_continue) begin
          n.runs    = satInc(m.runs, maxv);
          n.lastLat = 1;
        end else begin
          n.busy = 1'b1;
          n.lat  = 1;
        end
      end
    end else if (ap_done && ap_continue) begin
      n.busy    = 1'b0;
      n.runs    = satInc(m.runs, maxv);
      n.lastLat = m.lat;
    end else begin
      n.lat = satInc(m.lat, maxv);
    end
    pending = m.starts - m.ends;
    enter   = !m.active && (cur_state == iter_start_state)
              && (!pre_states_valid || m.prev == pre_loop_state0);
    inLoop  = m.active || enter;
    s = inLoop && (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    e = inLoop && (cur_state == iter_end_state) && iter_end_enable && !iter_end_block && (pending != 0);
    if (s) n.starts = satInc(m.starts, maxv);
    if (e) n.ends = satInc(m.ends, maxv);
    if (inLoop) n.cycles = satInc(m.cycles, maxv);
    if (inLoop && iter_start_block) n.stalls = satInc(m.stalls, maxv);
    if (enter) begin
      n.active  = 1'b1;
      n.entries = satInc(m.entries, maxv);
    end else if (m.active) begin
      leave = (post_states_valid && cur_state == post_loop_state0)
              || (quit_at_end ? (cur_state == loop_quit_state && e && !s && pending == 1)
                              : (m.prev == loop_quit_state && cur_state != loop_quit_state));
      if (leave) n.active = 1'b0;
    end
    n.prev = cur_state;
    return n;
  endfunction

  function automatic obs_t toObs(input model_t m);
    obs_t o;
    o.busy     = m.busy;
    o.runs     = 32'(m.runs);
    o.lastLat  = 32'(m.lastLat);
    o.active   = m.active;
    o.entries  = 32'(m.entries);
    o.starts   = 32'(m.starts);
    o.ends     = 32'(m.ends);
    o.inflight = 32'(m.starts - m.ends);
    o.cycles   = 32'(m.cycles);
    o.stalls   = 32'(m.stalls);
    o.frozen   = m.frozen;
    return o;
  endfunction

  // Monitor: pop one prediction per instance each cycle and compare on the falling edge
  always @(negedge clock) begin
    obs_t act;
    obs_t expected;
    cycleNo++;
    if (expQ32.size() > 0) begin
      expected = expQ32.pop_front();
      act = {busy32, runs32, lastLat32, active32, entries32, starts32, ends32,
             inflight32, cycles32, stalls32, frozen32};
      checks++;
      if (act !== expected) begin
        errors++;
        $display("[TB] FAIL out32 cycle %0d: got %h expected %h", cycleNo, act, expected);
      end
    end
    if (expQ4.size() > 0) begin
      expected = expQ4.pop_front();
      act = {busy4, 32'(runs4), 32'(lastLat4), active4, 32'(entries4), 32'(starts4),
             32'(ends4), 32'(inflight4), 32'(cycles4), 32'(stalls4), frozen4};
      checks++;
      if (act !== expected) begin
        errors++;
        $display("[TB] FAIL out4 cycle %0d: got %h expected %h", cycleNo, act, expected);
      end
    end
  end

  // Clock n edges with the current inputs, pushing the predicted outputs of each
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      m32 = modelStep(m32, 64'hFFFF_FFFF);
      m4  = modelStep(m4, 64'd15);
      expQ32.push_back(toObs(m32));
      expQ4.push_back(toObs(m4));
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    m32 = '{default: 0};
    m4  = '{default: 0};
    reset = 1'b1; finish = 1'b0;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    cur_state = OTHER_ST;
    pre_loop_state0 = PRE_ST;   pre_states_valid = 1'b1;
    post_loop_state0 = POST_ST; post_states_valid = 1'b1;
    iter_start_state = LOOP_ST; iter_end_state = LOOP_ST; loop_quit_state = LOOP_ST;
    iter_start_enable = 1'b0; iter_start_block = 1'b0;
    iter_end_enable = 1'b0;   iter_end_block = 1'b0;
    quit_at_end = 1'b1;
    #1;
    applyStimulus(2);
    reset = 1'b0;
    checkOutput("reset_runs", runs32, 0);
    checkOutput("reset_busy", busy32, 0);
    checkOutput("reset_frozen", frozen32, 0);

    $display("[TB] block transaction with 8-cycle latency");
    ap_start = 1'b1; applyStimulus(1);
    ap_start = 1'b0; applyStimulus(7);
    checkOutput("txn_busy_before_done", busy32, 1);
    ap_done = 1'b1; ap_ready = 1'b1; applyStimulus(1);
    ap_done = 1'b0; ap_ready = 1'b0;
    checkOutput("txn_runs", runs32, 1);
    checkOutput("txn_last_lat", lastLat32, 8);
    checkOutput("txn_busy_after_done", busy32, 0);

    $display("[TB] 10 iterations, depth 34, quit at end");
    cur_state = PRE_ST; applyStimulus(1);
    cur_state = LOOP_ST;
    for (int c = 0; c < 43; c++) begin
      iter_start_enable = (c < 10);
      iter_end_enable   = (c >= 33);
      if (c == 42) checkOutput("loop_active_before_last_end", active32, 1);
      applyStimulus(1);
    end
    iter_start_enable = 1'b0; iter_end_enable = 1'b0; cur_state = POST_ST;
    checkOutput("loop_starts", starts32, 10);
    checkOutput("loop_ends", ends32, 10);
    checkOutput("loop_active_after_last_end", active32, 0);
    checkOutput("loop_cycles", cycles32, 43);
    checkOutput("loop_entries", entries32, 1);

    $display("[TB] three stalled cycles");
    cur_state = PRE_ST; applyStimulus(1);
    cur_state = LOOP_ST;
    for (int c = 0; c < 9; c++) begin
      iter_start_enable = (c <= 5);
      iter_start_block  = (c >= 1 && c <= 3);
      iter_end_enable   = (c >= 6);
      applyStimulus(1);
      if (c == 3) checkOutput("stall_starts_held", starts32, 11);
    end
    iter_start_enable = 1'b0; iter_start_block = 1'b0; iter_end_enable = 1'b0;
    cur_state = OTHER_ST;
    checkOutput("stall_cycles", stalls32, 3);
    checkOutput("stall_starts", starts32, 13);
    checkOutput("stall_loop_exited", active32, 0);

    $display("[TB] early exit with quit_at_end=0");
    quit_at_end = 1'b0;
    cur_state = PRE_ST; applyStimulus(1);
    cur_state = LOOP_ST; iter_start_enable = 1'b1; applyStimulus(4);
    iter_start_enable = 1'b0; cur_state = OTHER_ST; applyStimulus(1);
    checkOutput("early_exit_active", active32, 0);
    checkOutput("early_exit_entries", entries32, 3);
    checkOutput("early_exit_inflight", inflight32, 4);

    $display("[TB] finish mid-loop");
    cur_state = PRE_ST; applyStimulus(1);
    cur_state = LOOP_ST; iter_start_enable = 1'b1; applyStimulus(2);
    finish = 1'b1; applyStimulus(1);
    finish = 1'b0; ap_start = 1'b1; applyStimulus(5);
    ap_start = 1'b0;
    checkOutput("freeze_starts", starts32, 19);
    checkOutput("freeze_frozen", frozen32, 1);
    checkOutput("freeze_active", active32, 1);
    checkOutput("freeze_busy", busy32, 0);
    iter_start_enable = 1'b0; cur_state = OTHER_ST; quit_at_end = 1'b1;
    reset = 1'b1; applyStimulus(1);
    reset = 1'b0;
    checkOutput("reset_after_freeze_frozen", frozen32, 0);
    checkOutput("reset_after_freeze_starts", starts32, 0);
    checkOutput("reset_after_freeze_cycles", cycles32, 0);
    checkOutput("reset_after_freeze_lat", lastLat32, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      int pick;
      pick = $urandom_range(0, 7);
      cur_state = (pick == 0) ? PRE_ST : (pick == 1) ? POST_ST : (pick == 2) ? OTHER_ST : LOOP_ST;
      ap_start          = ($urandom_range(0, 3) == 0);
      ap_done           = ($urandom_range(0, 3) == 0);
      ap_ready          = ap_done;
      ap_continue       = ($urandom_range(0, 3) != 0);
      iter_start_enable = $urandom_range(0, 1);
      iter_start_block  = ($urandom_range(0, 3) == 0);
      iter_end_enable   = $urandom_range(0, 1);
      iter_end_block    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) quit_at_end = ~quit_at_end;
      if ($urandom_range(0, 31) == 0) pre_states_valid = ~pre_states_valid;
      if ($urandom_range(0, 31) == 0) post_states_valid = ~post_states_valid;
      finish = ($urandom_range(0, 399) == 0);
      reset  = ($urandom_range(0, 99) == 0);
      applyStimulus(1);
    end

    $display("[TB] saturation with 20 iterations");
    finish = 1'b0; ap_start = 1'b0; ap_done = 1'b0; ap_ready = 1'b0; ap_continue = 1'b1;
    iter_start_block = 1'b0; iter_end_block = 1'b0; iter_end_enable = 1'b0;
    iter_start_enable = 1'b0; cur_state = OTHER_ST;
    reset = 1'b1; applyStimulus(1);
    reset = 1'b0; pre_states_valid = 1'b0; post_states_valid = 1'b1; quit_at_end = 1'b1;
    cur_state = LOOP_ST; iter_start_enable = 1'b1; applyStimulus(20);
    checkOutput("sat_starts4", starts4, 15);
    checkOutput("sat_starts32", starts32, 20);
    checkOutput("sat_cycles4", cycles4, 15);
    cur_state = POST_ST; iter_start_enable = 1'b0; applyStimulus(1);
    checkOutput("sat_forced_exit", active4, 0);
    ap_start = 1'b1; applyStimulus(1);
    ap_start = 1'b0; applyStimulus(3);
    ap_done = 1'b1; ap_continue = 1'b0; applyStimulus(1);
    ap_done = 1'b0; applyStimulus(2);
    checkOutput("no_continue_busy4", busy4, 1);
    checkOutput("no_continue_busy32", busy32, 1);
    checkOutput("no_continue_runs4", runs4, 0);

    @(negedge clock);
    #1;
    checkOutput("scoreboard_drained", expQ32.size() + expQ4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
